piso_serializer: RTL and testbench

//   Parallel-in serial-out transmitter built from a flip-flop shift register.

---
 rtl/piso_serializer.sv | 68 ++++++
 tb/tb_piso_serializer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready loaded parallel-in serial-out shift-register transmitter
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             async_reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             frame,
   output logic             done
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] sreg, sreg_n;
   logic [CW-1:0] cnt, cnt_n;
   logic serial_n, frame_n, done_n;
   assign load_ready = (state == IDLE);
   // next-state and next-output decode; the shift register rotates so the next bit always sits one slot behind the head
   always_comb begin
      state_n  = state;
      sreg_n   = sreg;
      cnt_n    = cnt;
      serial_n = 1'b0;
      frame_n  = 1'b0;
      done_n   = 1'b0;
      if (state == IDLE) begin
         if (load_valid) begin
            state_n  = SHIFT;
            sreg_n   = data_in;
            cnt_n    = CW'(1);
            serial_n = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
            frame_n  = 1'b1;
         end
      end else if (cnt == LAST) begin
         state_n = IDLE;
         cnt_n   = '0;
         done_n  = 1'b1;
      end else begin
         sreg_n   = MSB_FIRST ? {sreg[WIDTH-2:0], sreg[WIDTH-1]} : {sreg[0], sreg[WIDTH-1:1]};
         serial_n = MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
         cnt_n    = cnt + CW'(1);
         frame_n  = 1'b1;
      end
   end
   // state and registered outputs; reset aborts any frame immediately
   always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
         state      <= IDLE;
         sreg       <= '0;
         cnt        <= '0;
         serial_out <= 1'b0;
         frame      <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         sreg       <= sreg_n;
         cnt        <= cnt_n;
         serial_out <= serial_n;
         frame      <= frame_n;
         done       <= done_n;
      end
   end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: timeline model check of three serializer configurations sharing one stimulus
module tb_piso_serializer;
   localparam int N = 1024;
   logic clk = 1'b0, rst = 1'b1, load_valid = 1'b0;
   logic [7:0] data_in = '0;
   logic [2:0] ready, so, fr, dn;
   int wid [3] = '{8, 8, 2};
   bit msb [3] = '{1'b1, 1'b0, 1'b1};
   bit eb [3][N];
   bit ef [3][N];
   bit ed [3][N];
   int free_at [3] = '{0, 0, 0};
   int cyc = 0;
   int vectors = 0, miscompares = 0;
   logic [31:0] rec [3];
   int ndone [3];
   always #5 clk = ~clk;
   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (.clk(clk), .async_reset(rst), .data_in(data_in),
      .load_valid(load_valid), .load_ready(ready[0]), .serial_out(so[0]), .frame(fr[0]), .done(dn[0]));
   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (.clk(clk), .async_reset(rst), .data_in(data_in),
      .load_valid(load_valid), .load_ready(ready[1]), .serial_out(so[1]), .frame(fr[1]), .done(dn[1]));
   piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u2 (.clk(clk), .async_reset(rst), .data_in(data_in[1:0]),
      .load_valid(load_valid), .load_ready(ready[2]), .serial_out(so[2]), .frame(fr[2]), .done(dn[2]));
   task automatic check(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s u%0d cyc=%0d: got %0h expected %0h", nm, u, cyc, act, exp);
      end
   endtask
   task automatic abort();
      for (int i = 0; i < 3; i++) begin
         for (int j = cyc; j < N; j++) begin
            eb[i][j] = 1'b0;
            ef[i][j] = 1'b0;
            ed[i][j] = 1'b0;
         end
         free_at[i] = 0;
      end
   endtask
   task automatic clear_rec();
      for (int i = 0; i < 3; i++) begin
         rec[i] = '0;
         ndone[i] = 0;
      end
   endtask
   task automatic send(input logic [7:0] w);
      clear_rec();
      data_in = w;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      repeat (12) @(negedge clk);
   endtask
   // model: an accepted word paints its bit window and done pulse onto a per-cycle timeline
   initial forever begin
      @(posedge clk);
      cyc++;
      if (!rst && load_valid)
         for (int i = 0; i < 3; i++)
            if (cyc >= free_at[i] && cyc + wid[i] < N) begin
               for (int k = 0; k < wid[i]; k++) begin
                  eb[i][cyc+k] = msb[i] ? data_in[wid[i]-1-k] : data_in[k];
                  ef[i][cyc+k] = 1'b1;
               end
               ed[i][cyc+wid[i]] = 1'b1;
               free_at[i] = cyc + wid[i] + 1;
            end
   end
   initial forever begin
      @(negedge clk);
      if (cyc < N)
         for (int i = 0; i < 3; i++) begin
            check("serial_out", i, 32'(so[i]), 32'(eb[i][cyc]));
            check("frame", i, 32'(fr[i]), 32'(ef[i][cyc]));
            check("done", i, 32'(dn[i]), 32'(ed[i][cyc]));
            check("load_ready", i, 32'(ready[i]), 32'(cyc + 1 >= free_at[i]));
         end
   end
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         if (fr[i] === 1'b1) rec[i] = {rec[i][30:0], so[i]};
         if (dn[i] === 1'b1) ndone[i]++;
      end
   end
   initial begin
      clear_rec();
      load_valid = 1'b1;
      data_in = 8'hA5;
      repeat (3) @(negedge clk);
      load_valid = 1'b0;
      rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) check("ready_after_reset", i, 32'(ready[i]), 32'd1);
      @(negedge clk);
      send(8'hA5);
      check("a5_msb", 0, rec[0], 32'hA5);
      check("a5_lsb", 1, rec[1], 32'hA5);
      check("a5_w2", 2, rec[2], 32'h1);
      for (int i = 0; i < 3; i++) check("a5_done", i, 32'(ndone[i]), 32'd1);
      send(8'h01);
      check("01_msb", 0, rec[0], 32'h01);
      check("01_lsb", 1, rec[1], 32'h80);
      check("01_w2", 2, rec[2], 32'h1);
      clear_rec();
      data_in = 8'hFF;
      load_valid = 1'b1;
      @(negedge clk);
      data_in = 8'h00;
      repeat (9) @(negedge clk);
      load_valid = 1'b0;
      repeat (12) @(negedge clk);
      check("b2b_msb", 0, rec[0], 32'hFF00);
      check("b2b_lsb", 1, rec[1], 32'hFF00);
      check("b2b_w2", 2, rec[2], 32'hC0);
      check("b2b_done", 0, 32'(ndone[0]), 32'd2);
      check("b2b_done", 2, 32'(ndone[2]), 32'd4);
      clear_rec();
      data_in = 8'hC3;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      repeat (2) @(negedge clk);
      data_in = 8'h3C;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      data_in = 8'h00;
      repeat (12) @(negedge clk);
      check("ignore_msb", 0, rec[0], 32'hC3);
      check("ignore_lsb", 1, rec[1], 32'hC3);
      check("ignore_w2", 2, rec[2], 32'hC);
      check("ignore_done", 0, 32'(ndone[0]), 32'd1);
      clear_rec();
      data_in = 8'hF0;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      abort();
      #1;
      for (int i = 0; i < 2; i++) begin
         check("abort_frame", i, 32'(fr[i]), 32'd0);
         check("abort_serial", i, 32'(so[i]), 32'd0);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_nodone", 0, 32'(ndone[0]), 32'd0);
      check("abort_nodone", 1, 32'(ndone[1]), 32'd0);
      send(8'h02);
      check("post_abort_msb", 0, rec[0], 32'h02);
      check("post_abort_lsb", 1, rec[1], 32'h40);
      check("post_abort_w2", 2, rec[2], 32'h2);
      for (int i = 0; i < 3; i++) check("post_abort_done", i, 32'(ndone[i]), 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
